// File: rtl/uart_rx_fifo_param_if.sv
// uart_rx_fifo_param_if: receive-side valid/ready bus carrying the FIFO head entry.
//   rx_data, rx_valid, parity_error, framing_error : producer -> consumer
//   rx_ready                                        : consumer -> producer
interface uart_rx_fifo_param_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic parity_error;
  logic framing_error;
  modport master(output rx_data, rx_valid, parity_error, framing_error, input rx_ready);
  modport slave(input rx_data, rx_valid, parity_error, framing_error, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo_param.sv
// uart_rx_fifo_param: parametrised UART receiver with a frame FIFO on a valid/ready bus.
//   clk     : system clock, rising edge
//   nRst    : asynchronous active-low reset
//   enable  : receiver enable; low forces the FSM idle, the FIFO keeps working
//   Rx      : asynchronous serial line, idle high
//   rx      : head entry bus (data, valid, ready, parity/framing error flags)
//   overrun : sticky, a frame was dropped on a full FIFO; cleared by the next pop
//   busy    : receiver FSM not idle
module uart_rx_fifo_param #(
  parameter int CLOCK_FREQ  = 50000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 2,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic clk,
  input  logic nRst,
  input  logic enable,
  input  logic Rx,
  uart_rx_fifo_param_if.master rx,
  output logic overrun,
  output logic busy
);
  localparam int DIV  = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = DIV > 1 ? $clog2(DIV) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int EW   = DATA_BITS + 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic s1, rxs;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] bidx, bidx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic pe, pe_n, fe, fe_n, push, tick, full, do_pop, do_push;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] din, head;
  logic [AW-1:0] rptr, wptr;
  logic [AW:0] count;
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) {s1, rxs} <= 2'b11;
    else {s1, rxs} <= {Rx, s1};
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      state <= IDLE;
      cnt   <= '0;
      bidx  <= '0;
      sh    <= '0;
      pe    <= 1'b0;
      fe    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bidx  <= bidx_n;
      sh    <= sh_n;
      pe    <= pe_n;
      fe    <= fe_n;
    end
  assign tick = cnt == CW'(DIV - 1);
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    bidx_n  = bidx;
    sh_n    = sh;
    pe_n    = pe;
    fe_n    = fe;
    push    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n  = '0;
        bidx_n = '0;
        pe_n   = 1'b0;
        fe_n   = 1'b0;
        state_n = rxs ? IDLE : START;
      end
      START: if (cnt == CW'(HALF - 1)) begin
        cnt_n   = '0;
        state_n = rxs ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_n  = '0;
        sh_n   = {rxs, sh[DATA_BITS-1:1]};
        bidx_n = bidx + 1'b1;
        if (bidx == 4'(DATA_BITS - 1)) begin
          bidx_n  = '0;
          state_n = PARITY_MODE != 0 ? PARITY : STOP;
        end
      end
      // odd mode flags an even total, even mode flags an odd total
      PARITY: if (tick) begin
        cnt_n   = '0;
        pe_n    = (^sh) ^ rxs ^ (PARITY_MODE == 1);
        state_n = STOP;
      end
      STOP: if (tick) begin
        cnt_n  = '0;
        fe_n   = fe | ~rxs;
        bidx_n = bidx + 1'b1;
        if (bidx == 4'(STOP_BITS - 1)) begin
          push    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      bidx_n  = '0;
      sh_n    = '0;
      push    = 1'b0;
    end
  end
  // the final stop sample is folded in directly since fe only updates on this edge
  assign din     = {sh, pe, fe | ~rxs};
  assign full    = count == (AW+1)'(FIFO_DEPTH);
  assign do_pop  = rx.rx_ready && count != 0;
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;
  // head is registered so it holds the last shown entry once the FIFO drains
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      rptr    <= '0;
      wptr    <= '0;
      count   <= '0;
      head    <= '0;
      overrun <= 1'b0;
    end else begin
      rptr  <= rptr + AW'(do_pop);
      wptr  <= wptr + AW'(do_push);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (push && full && !do_pop) overrun <= 1'b1;
      else if (do_pop) overrun <= 1'b0;
      if (do_pop && count > (AW+1)'(1)) head <= mem[AW'(rptr + 1'b1)];
      else if (do_push && (count == 0 || (do_pop && count == (AW+1)'(1)))) head <= din;
    end
  assign rx.rx_data       = head[EW-1:2];
  assign rx.parity_error  = head[1];
  assign rx.framing_error = head[0];
  assign rx.rx_valid      = count != 0;
  assign busy             = state != IDLE;
endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// tb_uart_rx_fifo_param: scoreboard bench for two receiver configurations (8E1 and 7O2).
module tb_uart_rx_fifo_param;
  logic tb_clk = 1'b0;
  logic nRst = 1'b0;
  logic en0 = 1'b1, en1 = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1;
  logic ovr0, ovr1, busy0, busy1;
  int n_cmp = 0, n_err = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  always #5 tb_clk = ~tb_clk;
  uart_rx_fifo_param_if #(.DATA_BITS(8)) if0();
  uart_rx_fifo_param_if #(.DATA_BITS(7)) if1();
  uart_rx_fifo_param #(.CLOCK_FREQ(160000), .BAUD_RATE(10000), .DATA_BITS(8), .PARITY_MODE(2),
    .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (.clk(tb_clk), .nRst(nRst), .enable(en0), .Rx(rx0),
    .rx(if0.master), .overrun(ovr0), .busy(busy0));
  uart_rx_fifo_param #(.CLOCK_FREQ(160000), .BAUD_RATE(10000), .DATA_BITS(7), .PARITY_MODE(1),
    .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (.clk(tb_clk), .nRst(nRst), .enable(en1), .Rx(rx1),
    .rx(if1.master), .overrun(ovr1), .busy(busy1));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(posedge tb_clk);
    #1;
  endtask
  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx0 = v;
    else rx1 = v;
  endtask
  task automatic drive_bit(input int sel, input logic v);
    set_rx(sel, v);
    wait_clk(16);
  endtask
  task automatic send(input int sel, input logic [8:0] d, input int nb, input int pm, input int sb,
                      input bit invp, input bit bads);
    logic p;
    p = 1'b0;
    for (int i = 0; i < nb; i++) p = p ^ d[i];
    if (pm == 1) p = ~p;
    if (invp) p = ~p;
    drive_bit(sel, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(sel, d[i]);
    if (pm != 0) drive_bit(sel, p);
    for (int i = 0; i < sb; i++) drive_bit(sel, bads ? 1'b0 : 1'b1);
    drive_bit(sel, 1'b1);
  endtask
  function automatic logic vld(input int sel);
    return sel == 0 ? if0.rx_valid : if1.rx_valid;
  endfunction
  function automatic logic [31:0] head(input int sel);
    return sel == 0 ? {22'd0, if0.rx_data, if0.parity_error, if0.framing_error}
                    : {23'd0, if1.rx_data, if1.parity_error, if1.framing_error};
  endfunction
  function automatic logic [31:0] ent(input logic [8:0] d, input bit pe, input bit fe);
    return {21'd0, d, pe, fe};
  endfunction
  task automatic pop_chk(input int sel, input string tag);
    int n;
    logic [31:0] e;
    n = 0;
    while (!vld(sel) && n < 400) begin
      wait_clk(1);
      n++;
    end
    if (!vld(sel) || (sel == 0 ? q0.size() : q1.size()) == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    else begin
      e = sel == 0 ? q0.pop_front() : q1.pop_front();
      check(tag, head(sel), e);
      if (sel == 0) if0.rx_ready = 1'b1;
      else if1.rx_ready = 1'b1;
      wait_clk(1);
      if0.rx_ready = 1'b0;
      if1.rx_ready = 1'b0;
    end
  endtask
  initial begin
    if0.rx_ready = 1'b0;
    if1.rx_ready = 1'b0;
    wait_clk(3);
    check("rst_valid", if0.rx_valid, 0);
    check("rst_head", head(0), 0);
    check("rst_ovr", ovr0, 0);
    check("rst_busy", busy0, 0);
    check("rst_valid1", if1.rx_valid, 0);
    nRst = 1'b1;
    wait_clk(5);
    send(0, 9'h0A5, 8, 2, 1, 0, 0);
    q0.push_back(ent(9'h0A5, 0, 0));
    check("t1_valid", if0.rx_valid, 1);
    pop_chk(0, "t1_pop");
    check("t1_empty", if0.rx_valid, 0);
    check("t1_hold", head(0), ent(9'h0A5, 0, 0));
    send(0, 9'h03C, 8, 2, 1, 1, 0);
    q0.push_back(ent(9'h03C, 1, 0));
    pop_chk(0, "t2_pop");
    send(0, 9'h055, 8, 2, 1, 0, 1);
    q0.push_back(ent(9'h055, 0, 1));
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    send(0, 9'h001, 8, 2, 1, 0, 0);
    q0.push_back(ent(9'h001, 0, 0));
    pop_chk(0, "t3_bad_stop");
    pop_chk(0, "t3_next");
    check("t3_empty", if0.rx_valid, 0);
    rx0 = 1'b0;
    wait_clk(4);
    check("t4_busy", busy0, 1);
    rx0 = 1'b1;
    wait_clk(20);
    check("t4_idle", busy0, 0);
    check("t4_nopush", if0.rx_valid, 0);
    for (int i = 0; i < 5; i++) begin
      send(0, 9'(8'h10 + i), 8, 2, 1, 0, 0);
      if (i < 4) q0.push_back(ent(9'(8'h10 + i), 0, 0));
    end
    check("t5_ovr", ovr0, 1);
    pop_chk(0, "t5_pop0");
    check("t5_ovr_clr", ovr0, 0);
    for (int i = 1; i < 4; i++) pop_chk(0, "t5_pop");
    check("t5_empty", if0.rx_valid, 0);
    check("t5_hold", head(0), ent(9'h013, 0, 0));
    rx0 = 1'b0;
    wait_clk(16);
    rx0 = 1'b1;
    wait_clk(8);
    check("t6_busy", busy0, 1);
    en0 = 1'b0;
    wait_clk(1);
    check("t6_en_idle", busy0, 0);
    en0 = 1'b1;
    wait_clk(200);
    check("t6_discard", if0.rx_valid, 0);
    send(0, 9'h042, 8, 2, 1, 0, 0);
    check("t6_pre_rst", if0.rx_valid, 1);
    rx0 = 1'b0;
    wait_clk(40);
    check("t6_busy2", busy0, 1);
    nRst = 1'b0;
    #1;
    check("t6_rst_valid", if0.rx_valid, 0);
    check("t6_rst_head", head(0), 0);
    check("t6_rst_ovr", ovr0, 0);
    check("t6_rst_busy", busy0, 0);
    rx0 = 1'b1;
    wait_clk(2);
    nRst = 1'b1;
    wait_clk(200);
    check("t6_post_rst", if0.rx_valid, 0);
    send(1, 9'h07F, 7, 1, 2, 0, 0);
    q1.push_back(ent(9'h07F, 0, 0));
    pop_chk(1, "t6_7o2");
    check("t6_7o2_ovr", ovr1, 0);
    check("t6_7o2_empty", if1.rx_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
